bit_multiplier4: RTL and testbench
==================================

// Module: bit_multiplier4
// PURPOSE
//  Unsigned 4x4-bit multiplier producing an 8-bit product.
//  Built as an array multiplier: AND-gate partial products feed ripple-carry adder rows.
//  The product is captured in an output register with a valid flag.
//  Used as a small registered arithmetic leaf inside datapaths.
// PARAMETERS
//  None. Widths are fixed: 4-bit operands, 8-bit product.
// PORTS
//  clk       input   1  single clock; all state updates on rising edge
//  rst       input   1  synchronous, active-high reset
//  in_valid  input   1  x/y valid this cycle; sample and multiply
//  x         input   4  multiplicand, unsigned
//  y         input   4  multiplier, unsigned
//  z         output  8  registered product x*y, unsigned
//  out_valid output  1  z holds a new product this cycle (1-cycle pulse per accepted input)
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is synchronous and active-high.
//  - Reset: on a rising clk edge with rst=1, z<=8'h00 and out_valid<=0.
//    rst has priority over in_valid.
//  - Datapath is combinational.
//    - Partial products: pp[i][j] = x[j] & y[i].
//    - Rows 1..3 are summed with full/half-adder ripple chains.
//    - Result is exact: x*y in 0..225. No truncation or overflow, since 15*15=225 fits in 8 bits.
//  - Latency: exactly 1 clock.
//    - in_valid=1 at edge N loads z<=x*y at edge N and sets out_valid=1 for the following cycle.
//  - in_valid=0 at an edge:
//    - z holds its previous value.
//    - out_valid<=0.
//  - Back-to-back: in_valid may be high every cycle. Full throughput, one product per clock, no stall and no ready signal.
//  - X/Y values while in_valid=0 are don't-care and must not change z.
//  - Reset mid-stream: a product launched in the same edge as rst=1 is discarded.
//    - z=0 and out_valid=0 after that edge.
//    - Normal operation resumes on the first edge with rst=0.
//  - Zero operand: either operand 0 gives z=0.
//  - No latches; no combinational path from inputs to outputs.
// TESTING
//  1. Reset: rst=1 for 2 clocks -> z=8'h00, out_valid=0. Check again after releasing rst with in_valid=0.
//  2. Directed products, one per clock, in_valid=1 on each. Each z appears 1 clock later with out_valid=1:
//     - x=8,  y=7  -> z=56  (8'b00111000)
//     - x=10, y=9  -> z=90  (8'b01011010)
//     - x=12, y=13 -> z=156 (8'b10011100)
//     - x=2,  y=11 -> z=22  (8'b00010110)
//  3. Corners:
//     - x=15, y=15 -> z=225 (8'hE1)
//     - x=0,  y=13 -> z=0
//     - x=1,  y=9  -> z=9
//  4. Hold: after x=15,y=15 accepted, drop in_valid and toggle x/y randomly for 3 clocks -> z stays 225, out_valid=0.
//  5. Reset priority: in_valid=1, x=12, y=13 with rst=1 on the same edge -> z=0, out_valid=0.
//     Next edge rst=0 with the same inputs -> z=156.
//  6. Exhaustive: all 256 (x,y) pairs streamed back-to-back -> each z equals x*y one clock later; out_valid high every cycle.

Source files
------------

// File: rtl/bit_multiplier4.sv
// bit_multiplier4: registered unsigned 4x4 array multiplier with valid flag
module bit_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module bit_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module bit_multiplier4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] z,
  output logic       out_valid
);
  logic [3:0][3:0] pp;
  logic [3:0][4:0] row;
  logic [3:1][3:0] c;
  logic [7:0]      prod;
  genvar i, j;
  generate
    for (i = 0; i < 4; i++) begin : g_pp
      for (j = 0; j < 4; j++) begin : g_bit
        assign pp[i][j] = x[j] & y[i];
      end
    end
    // each row adds the next partial product to the upper bits of the previous row
    for (i = 1; i < 4; i++) begin : g_row
      bit_ha u_ha (.a(row[i-1][1]), .b(pp[i][0]), .s(row[i][0]), .co(c[i][0]));
      for (j = 1; j < 4; j++) begin : g_fa
        bit_fa u_fa (.a(row[i-1][j+1]), .b(pp[i][j]), .ci(c[i][j-1]), .s(row[i][j]), .co(c[i][j]));
      end
      assign row[i][4] = c[i][3];
    end
  endgenerate
  assign row[0] = {1'b0, pp[0]};
  assign prod   = {row[3], row[2][0], row[1][0], row[0][0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      z         <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) z <= prod;
    end
  end
endmodule

// File: tb/tb_bit_multiplier4.sv
// tb_bit_multiplier4: directed and exhaustive checks against an arithmetic model
module tb_bit_multiplier4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] x = 4'd0;
  logic [3:0] y = 4'd0;
  logic [7:0] z;
  logic       out_valid;
  int         passed = 0;
  int         total = 0;
  logic [7:0] mz;
  logic       mv;
  logic       armed = 1'b0;

  bit_multiplier4 dut (.clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y), .z(z), .out_valid(out_valid));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      mz = 8'd0;
      mv = 1'b0;
    end else begin
      mv = in_valid;
      if (in_valid) mz = 8'(x) * 8'(y);
    end
    armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      total++;
      if (z === mz && out_valid === mv) passed++;
      else $display("FAIL model z=%0d out_valid=%b required z=%0d out_valid=%b", z, out_valid, mz, mv);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s got %0d required %0d", name, act, exp);
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b);
    rst = r; in_valid = v; x = a; y = b;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] vx [7] = '{4'd8, 4'd10, 4'd12, 4'd2, 4'd15, 4'd0, 4'd1};
  logic [3:0] vy [7] = '{4'd7, 4'd9, 4'd13, 4'd11, 4'd15, 4'd13, 4'd9};
  logic [7:0] vz [7] = '{8'd56, 8'd90, 8'd156, 8'd22, 8'hE1, 8'd0, 8'd9};

  initial begin
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_z", z, 8'h00);
    chk("reset_valid", {7'd0, out_valid}, 8'd0);
    step(0, 0, 4'd5, 4'd6);
    chk("idle_z", z, 8'h00);
    chk("idle_valid", {7'd0, out_valid}, 8'd0);
    for (int k = 0; k < 7; k++) begin
      step(0, 1, vx[k], vy[k]);
      chk($sformatf("prod_%0dx%0d", vx[k], vy[k]), z, vz[k]);
      chk("prod_valid", {7'd0, out_valid}, 8'd1);
    end
    step(0, 1, 4'd15, 4'd15);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 4'($urandom_range(15)), 4'($urandom_range(15)));
      chk("hold_z", z, 8'd225);
      chk("hold_valid", {7'd0, out_valid}, 8'd0);
    end
    step(1, 1, 4'd12, 4'd13);
    chk("rst_prio_z", z, 8'd0);
    chk("rst_prio_valid", {7'd0, out_valid}, 8'd0);
    step(0, 1, 4'd12, 4'd13);
    chk("resume_z", z, 8'd156);
    chk("resume_valid", {7'd0, out_valid}, 8'd1);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step(0, 1, 4'(a), 4'(b));
    chk("exh_last_z", z, 8'd225);
    step(0, 0, 0, 0);
    chk("end_valid", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
